// File: rtl/xor_seq_pkg.sv
// Shared types and constants for the XOR checksum sequencer.
package xor_seq_pkg;

    localparam int unsigned COUNT_W = 16;
    localparam logic [COUNT_W-1:0] COUNT_MAX = 16'hFFFF;

    // COLLECT stages bytes, FOLD runs one array pass, DONE presents the result.
    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        FOLD    = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/xor4x8_checksum_seq_if.sv
// Byte input stream and checksum output stream of the sequencer.
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high; the sender holds data stable while valid is high and ready
// is low, and ready never depends combinationally on valid.
interface xor4x8_checksum_seq_if;
    import xor_seq_pkg::*;

    logic [7:0]         I;
    logic               I_valid;
    logic               I_last;
    logic               I_ready;
    logic [7:0]         O;
    logic [COUNT_W-1:0] O_count;
    logic               O_valid;
    logic               O_ready;

    // Upstream/downstream side (drives bytes, accepts results).
    modport master (
        output I, I_valid, I_last, O_ready,
        input  I_ready, O, O_count, O_valid
    );

    // Sequencer side.
    modport slave (
        input  I, I_valid, I_last, O_ready,
        output I_ready, O, O_count, O_valid
    );

endinterface

// File: rtl/XOr4x8.sv
// Four-input, 8-bit wide bitwise XOR array.
module XOr4x8 (
    input  logic [7:0] I0,
    input  logic [7:0] I1,
    input  logic [7:0] I2,
    input  logic [7:0] I3,
    output logic [7:0] O
);

    // Fold all four operands bit by bit.
    always_comb begin
        O = I0 ^ I1 ^ I2 ^ I3;
    end

endmodule

// File: rtl/xor4x8_checksum_seq.sv
// Streaming XOR checksum: bytes are staged three at a time and folded into a
// running accumulator through a single shared XOr4x8 array, with the
// accumulator riding on the fourth array input.
module xor4x8_checksum_seq
    import xor_seq_pkg::*;
#(
    parameter logic [7:0] SEED = 8'h00
) (
    input  logic                  CLK,
    input  logic                  ASYNCRESETN,
    xor4x8_checksum_seq_if.slave  bus,
    output state_t                dbg_state
);

    state_t             state_q;
    state_t             state_d;
    logic [2:0][7:0]    slot_q;
    logic [1:0]         cnt_q;
    logic [COUNT_W-1:0] bcnt_q;
    logic [7:0]         acc_q;
    logic               last_q;
    logic [7:0]         fold_out;
    logic               accept;

    // Ready is a pure function of state so upstream never sees a comb loop.
    assign accept    = (state_q == COLLECT) && bus.I_valid;
    assign dbg_state = state_q;

    XOr4x8 u_xor (
        .I0 (acc_q),
        .I1 (slot_q[0]),
        .I2 (slot_q[1]),
        .I3 (slot_q[2]),
        .O  (fold_out)
    );

    // State register.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: fold on a full group or packet end, present on packet end.
    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: begin
                if (accept && ((cnt_q == 2'd2) || bus.I_last)) begin
                    state_d = FOLD;
                end
            end
            FOLD:    state_d = last_q ? DONE : COLLECT;
            DONE: begin
                if (bus.O_ready) begin
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // Output decode; result fields read zero whenever no result is offered.
    always_comb begin
        bus.I_ready = (state_q == COLLECT);
        bus.O_valid = (state_q == DONE);
        bus.O       = 8'h00;
        bus.O_count = '0;
        if (state_q == DONE) begin
            bus.O       = acc_q;
            bus.O_count = bcnt_q;
        end
    end

    // Staging slots, counters and accumulator.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            slot_q <= '0;
            cnt_q  <= 2'd0;
            bcnt_q <= '0;
            acc_q  <= SEED;
            last_q <= 1'b0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (accept) begin
                        slot_q[cnt_q] <= bus.I;
                        cnt_q         <= cnt_q + 2'd1;
                        if (bcnt_q != COUNT_MAX) begin
                            bcnt_q <= bcnt_q + 1'b1;
                        end
                        last_q <= bus.I_last;
                    end
                end
                FOLD: begin
                    // Unfilled slots are still zero, so a short group folds cleanly.
                    acc_q  <= fold_out;
                    slot_q <= '0;
                    cnt_q  <= 2'd0;
                    last_q <= 1'b0;
                end
                DONE: begin
                    if (bus.O_ready) begin
                        acc_q  <= SEED;
                        bcnt_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_xor4x8_checksum_seq.sv
// Directed bench for the XOR checksum sequencer.
module tb_xor4x8_checksum_seq;
    import xor_seq_pkg::*;

    logic   CLK;
    logic   ASYNCRESETN;
    state_t dbg_a;
    state_t dbg_b;
    int     n_checks;
    int     n_errors;
    int     fold_cnt;
    int     hs_cnt;

    xor4x8_checksum_seq_if bus_a ();
    xor4x8_checksum_seq_if bus_b ();

    xor4x8_checksum_seq #(.SEED(8'h00)) dut_a (
        .CLK         (CLK),
        .ASYNCRESETN (ASYNCRESETN),
        .bus         (bus_a.slave),
        .dbg_state   (dbg_a)
    );

    xor4x8_checksum_seq #(.SEED(8'hA5)) dut_b (
        .CLK         (CLK),
        .ASYNCRESETN (ASYNCRESETN),
        .bus         (bus_b.slave),
        .dbg_state   (dbg_b)
    );

    // Clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Count FOLD cycles and output handshakes of instance a.
    always @(negedge CLK) begin
        if (dbg_a == FOLD) fold_cnt++;
    end
    always @(posedge CLK) begin
        if (bus_a.O_valid && bus_a.O_ready) hs_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Offer one byte on stream a and return one tick after it is accepted.
    task automatic send_a(input logic [7:0] b, input logic last);
        int waited;
        waited = 0;
        bus_a.I       = b;
        bus_a.I_last  = last;
        bus_a.I_valid = 1'b1;
        while (!bus_a.I_ready && waited < 10) begin
            tick();
            waited++;
        end
        if (waited >= 10) chk("send_a_timeout", 32'(bus_a.I_ready), 32'd1);
        tick();
        bus_a.I_valid = 1'b0;
        bus_a.I_last  = 1'b0;
    endtask

    task automatic wait_valid_a(input string tag);
        for (int i = 0; i < 10 && !bus_a.O_valid; i++) tick();
        chk(tag, 32'(bus_a.O_valid), 32'd1);
    endtask

    task automatic handshake_a();
        bus_a.O_ready = 1'b1;
        tick();
        bus_a.O_ready = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        fold_cnt = 0;
        hs_cnt   = 0;
        ASYNCRESETN   = 1'b0;
        bus_a.I       = 8'h00;
        bus_a.I_valid = 1'b0;
        bus_a.I_last  = 1'b0;
        bus_a.O_ready = 1'b0;
        bus_b.I       = 8'h00;
        bus_b.I_valid = 1'b0;
        bus_b.I_last  = 1'b0;
        bus_b.O_ready = 1'b0;

        // Reset values.
        #12;
        chk("rst_o_valid", 32'(bus_a.O_valid), 32'd0);
        chk("rst_o",       32'(bus_a.O),       32'h00);
        chk("rst_o_count", 32'(bus_a.O_count), 32'd0);
        chk("rst_i_ready", 32'(bus_a.I_ready), 32'd1);
        #10;
        ASYNCRESETN = 1'b1;
        tick();
        chk("post_rst_i_ready", 32'(bus_a.I_ready), 32'd1);
        chk("post_rst_state",   32'(dbg_a),         32'(COLLECT));

        // Packet 01,02,04: O_valid two cycles after the last accept.
        send_a(8'h01, 1'b0);
        send_a(8'h02, 1'b0);
        send_a(8'h04, 1'b1);
        chk("p1_fold_state",   32'(dbg_a),         32'(FOLD));
        chk("p1_fold_i_ready", 32'(bus_a.I_ready), 32'd0);
        chk("p1_fold_o_valid", 32'(bus_a.O_valid), 32'd0);
        tick();
        chk("p1_o_valid",    32'(bus_a.O_valid), 32'd1);
        chk("p1_o",          32'(bus_a.O),       32'h07);
        chk("p1_o_count",    32'(bus_a.O_count), 32'd3);
        chk("p1_done_ready", 32'(bus_a.I_ready), 32'd0);
        handshake_a();
        chk("p1_after_hs", 32'(bus_a.O_valid), 32'd0);

        // Packet FF,00,FF,0F,F0 with a partial second group.
        fold_cnt = 0;
        send_a(8'hFF, 1'b0);
        send_a(8'h00, 1'b0);
        send_a(8'hFF, 1'b0);
        send_a(8'h0F, 1'b0);
        send_a(8'hF0, 1'b1);
        wait_valid_a("p2_wait_valid");
        chk("p2_o",       32'(bus_a.O),       32'hFF);
        chk("p2_o_count", 32'(bus_a.O_count), 32'd5);
        chk("p2_folds",   32'(fold_cnt),      32'd2);

        // Backpressure: result held while O_ready is low.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_o",       32'(bus_a.O),       32'hFF);
            chk("bp_o_count", 32'(bus_a.O_count), 32'd5);
            chk("bp_i_ready", 32'(bus_a.I_ready), 32'd0);
        end
        // Next byte offered together with the handshake; accepted one cycle later.
        bus_a.O_ready = 1'b1;
        bus_a.I       = 8'h3C;
        bus_a.I_last  = 1'b1;
        bus_a.I_valid = 1'b1;
        tick();
        bus_a.O_ready = 1'b0;
        chk("bp_hs_o_valid", 32'(bus_a.O_valid), 32'd0);
        chk("bp_hs_i_ready", 32'(bus_a.I_ready), 32'd1);
        tick();
        bus_a.I_valid = 1'b0;
        bus_a.I_last  = 1'b0;
        chk("p3_fold_state", 32'(dbg_a), 32'(FOLD));
        tick();
        chk("p3_o_valid", 32'(bus_a.O_valid), 32'd1);
        chk("p3_o",       32'(bus_a.O),       32'h3C);
        chk("p3_o_count", 32'(bus_a.O_count), 32'd1);
        handshake_a();

        // Non-zero seed, single-byte packet on instance b.
        bus_b.I       = 8'h5A;
        bus_b.I_last  = 1'b1;
        bus_b.I_valid = 1'b1;
        chk("seed_i_ready", 32'(bus_b.I_ready), 32'd1);
        tick();
        bus_b.I_valid = 1'b0;
        bus_b.I_last  = 1'b0;
        tick();
        chk("seed_o_valid", 32'(bus_b.O_valid), 32'd1);
        chk("seed_o",       32'(bus_b.O),       32'hFF);
        chk("seed_o_count", 32'(bus_b.O_count), 32'd1);
        bus_b.O_ready = 1'b1;
        tick();
        bus_b.O_ready = 1'b0;

        // Reset mid-packet discards the partial packet.
        send_a(8'h11, 1'b0);
        send_a(8'h22, 1'b0);
        #2;
        ASYNCRESETN = 1'b0;
        #1;
        chk("midrst_state",   32'(dbg_a),         32'(COLLECT));
        chk("midrst_o_valid", 32'(bus_a.O_valid), 32'd0);
        #1;
        ASYNCRESETN = 1'b1;
        hs_cnt = 0;
        send_a(8'h3C, 1'b1);
        wait_valid_a("midrst_wait_valid");
        chk("midrst_o",       32'(bus_a.O),       32'h3C);
        chk("midrst_o_count", 32'(bus_a.O_count), 32'd1);
        handshake_a();
        for (int i = 0; i < 4; i++) tick();
        chk("midrst_outputs", 32'(hs_cnt),        32'd1);
        chk("midrst_idle",    32'(bus_a.O_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
